// File: rtl/prog_ctr_seq.sv
// prog_ctr_seq: program counter with relative branches, call/return stack, stall and halt
module prog_ctr_seq #(
  parameter int A     = 10,
  parameter int OW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           Reset_n,
  input  logic                           Stall,
  input  logic                           Halt,
  input  logic                           Jump,
  input  logic                           Branch,
  input  logic                           Call,
  input  logic                           Ret,
  input  logic [A-1:0]                   Target,
  input  logic [OW-1:0]                  Offset,
  output logic [A-1:0]                   ProgCtr,
  output logic                           Running,
  output logic                           Halted,
  output logic [$clog2(DEPTH+1)-1:0]     Depth,
  output logic                           StackOvf,
  output logic                           StackUnf
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {START, RUN, HALT} state_t;
  state_t         st, st_n;
  logic [A-1:0]   pc_n, pc_inc;
  logic [DW-1:0]  dep_n;
  logic           ovf_n, unf_n, push;
  logic [A-1:0]   stk [DEPTH];
  assign pc_inc = ProgCtr + 1'b1;
  always_comb begin
    st_n  = st;
    pc_n  = ProgCtr;
    dep_n = Depth;
    ovf_n = StackOvf;
    unf_n = StackUnf;
    push  = 1'b0;
    if (st == START) st_n = RUN;
    else if (st == RUN && !Stall) begin
      if (Halt) st_n = HALT;
      else if (Ret) begin
        if (Depth == '0) begin
          unf_n = 1'b1;
          st_n  = HALT;
        end else begin
          pc_n  = stk[IW'(Depth - 1'b1)];
          dep_n = Depth - 1'b1;
        end
      end else if (Call) begin
        if (Depth == DW'(DEPTH)) begin
          ovf_n = 1'b1;
          st_n  = HALT;
        end else begin
          push  = 1'b1;
          pc_n  = Target;
          dep_n = Depth + 1'b1;
        end
      end else if (Jump) pc_n = Target;
      else if (Branch) pc_n = ProgCtr + A'($signed(Offset));
      else pc_n = pc_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      st       <= START;
      ProgCtr  <= '0;
      Depth    <= '0;
      StackOvf <= 1'b0;
      StackUnf <= 1'b0;
      Running  <= 1'b0;
      Halted   <= 1'b0;
    end else begin
      st       <= st_n;
      ProgCtr  <= pc_n;
      Depth    <= dep_n;
      StackOvf <= ovf_n;
      StackUnf <= unf_n;
      Running  <= st_n == RUN;
      Halted   <= st_n == HALT;
    end
  end
  // stack contents need no reset; Depth alone marks which entries are valid
  always_ff @(posedge clk) begin
    if (Reset_n && push) stk[IW'(Depth)] <= pc_inc;
  end
endmodule

// File: tb/tb_prog_ctr_seq.sv
// tb_prog_ctr_seq: directed and random checks of prog_ctr_seq against a queue-based model
module tb_prog_ctr_seq;
  localparam int A = 10, OW = 8, DEPTH = 4, N = 1 << A;
  logic clk = 1'b0;
  logic rst_n, stall, halt, jump, branch, call, ret;
  logic [A-1:0] target;
  logic [OW-1:0] offset;
  logic [A-1:0] pc;
  logic running, halted, ovf, unf;
  logic [$clog2(DEPTH+1)-1:0] depth;
  int checks = 0, errors = 0;
  int m_pc = 0, m_st = 0, m_ovf = 0, m_unf = 0;
  int m_stk[$];

  prog_ctr_seq #(.A(A), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .Reset_n(rst_n), .Stall(stall), .Halt(halt), .Jump(jump),
    .Branch(branch), .Call(call), .Ret(ret), .Target(target), .Offset(offset),
    .ProgCtr(pc), .Running(running), .Halted(halted), .Depth(depth),
    .StackOvf(ovf), .StackUnf(unf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; halt = 0; jump = 0; branch = 0; call = 0; ret = 0;
  endtask

  // model: 0=START 1=RUN 2=HALT; stack is a plain queue
  task automatic model();
    int soff;
    soff = offset >= (1 << (OW - 1)) ? int'(offset) - (1 << OW) : int'(offset);
    if (!rst_n) begin
      m_pc = 0; m_st = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
    end else if (m_st == 0) m_st = 1;
    else if (m_st == 1 && !stall) begin
      if (halt) m_st = 2;
      else if (ret) begin
        if (m_stk.size() == 0) begin m_unf = 1; m_st = 2; end
        else m_pc = m_stk.pop_back();
      end else if (call) begin
        if (m_stk.size() == DEPTH) begin m_ovf = 1; m_st = 2; end
        else begin m_stk.push_back((m_pc + 1) % N); m_pc = int'(target); end
      end else if (jump) m_pc = int'(target);
      else if (branch) m_pc = ((m_pc + soff) % N + N) % N;
      else m_pc = (m_pc + 1) % N;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("pc", int'(pc), m_pc);
    chk("running", int'(running), int'(m_st == 1));
    chk("halted", int'(halted), int'(m_st == 2));
    chk("depth", int'(depth), m_stk.size());
    chk("ovf", int'(ovf), m_ovf);
    chk("unf", int'(unf), m_unf);
  endtask

  task automatic restart();
    idle(); rst_n = 0; tick(); rst_n = 1; tick();
  endtask

  initial begin
    idle(); target = '0; offset = '0; rst_n = 0;
    tick();
    chk("rst_pc", int'(pc), 0); chk("rst_run", int'(running), 0);
    rst_n = 1; tick();
    chk("start_pc", int'(pc), 0); chk("run_rise", int'(running), 1);
    tick(); chk("seq1", int'(pc), 1);
    tick(); chk("seq2", int'(pc), 2);
    tick(); chk("seq3", int'(pc), 3);
    tick(); tick(); chk("at5", int'(pc), 5);
    branch = 1; offset = 8'hFD; tick(); chk("br_neg", int'(pc), 2);
    idle(); jump = 1; target = 10'd1020; tick();
    idle(); branch = 1; offset = 8'd8; tick(); chk("br_wrap", int'(pc), 4);
    idle(); offset = 8'h80; branch = 1; tick(); chk("br_min", int'(pc), 900);
    idle(); jump = 1; target = 10'd10; tick();
    idle(); call = 1; target = 10'd100; tick();
    chk("call_pc", int'(pc), 100); chk("call_dep", int'(depth), 1);
    idle(); tick(); tick(); chk("at102", int'(pc), 102);
    ret = 1; tick(); chk("ret_pc", int'(pc), 11); chk("ret_dep", int'(depth), 0);
    idle(); jump = 1; target = 10'd7; tick();
    stall = 1; target = 10'd50; halt = 1; call = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall_pc", int'(pc), 7); end
    idle(); jump = 1; target = 10'd50; tick(); chk("unstall", int'(pc), 50);
    idle(); call = 1; target = 10'd60; tick();
    ret = 1; tick(); chk("callret_pc", int'(pc), 51); chk("callret_dep", int'(depth), 0);
    idle();
    for (int i = 0; i < 5; i++) begin call = 1; target = A'(200 + i); tick(); end
    chk("ovf_flag", int'(ovf), 1); chk("ovf_halt", int'(halted), 1);
    chk("ovf_dep", int'(depth), 4); chk("ovf_pc", int'(pc), 203);
    idle(); ret = 1; jump = 1; tick(); tick(); chk("halt_hold", int'(pc), 203);
    restart();
    ret = 1; tick(); chk("unf_flag", int'(unf), 1); chk("unf_halt", int'(halted), 1);
    restart();
    for (int i = 0; i < 3; i++) begin call = 1; target = A'(300 + 4 * i); tick(); end
    idle(); halt = 1; tick(); chk("pre_rst_dep", int'(depth), 3);
    rst_n = 0; tick();
    chk("rst2_pc", int'(pc), 0); chk("rst2_dep", int'(depth), 0); chk("rst2_halt", int'(halted), 0);
    idle(); rst_n = 1; tick(); chk("rst2_start", int'(pc), 0);
    tick(); chk("rst2_seq1", int'(pc), 1);
    for (int i = 0; i < 3000; i++) begin
      rst_n  = !($urandom_range(0, 99) == 0 || (m_st == 2 && $urandom_range(0, 7) == 0));
      stall  = $urandom_range(0, 3) == 0;
      halt   = $urandom_range(0, 39) == 0;
      ret    = $urandom_range(0, 4) == 0;
      call   = $urandom_range(0, 3) == 0;
      jump   = $urandom_range(0, 6) == 0;
      branch = $urandom_range(0, 2) == 0;
      target = A'($urandom);
      offset = OW'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
